// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared types and constants for the three-digit seven-segment scan driver:
//   - converter FSM state encoding
//   - active-low segment patterns {g,f,e,d,c,b,a} and the blank pattern
//   - digit-index and BCD nibble types
//   - helper functions for segment decode and the double-dabble adjust step
// -----------------------------------------------------------------------------
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2
    } conv_state_e;

    typedef logic [1:0] digit_idx_t;
    typedef logic [3:0] bcd_nibble_t;

    localparam digit_idx_t IDX_UNITS    = 2'd0;
    localparam digit_idx_t IDX_TENS     = 2'd1;
    localparam digit_idx_t IDX_HUNDREDS = 2'd2;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Decode one BCD nibble to its active-low pattern; non-decimal codes go dark.
    function automatic logic [6:0] seg_decode(input bcd_nibble_t nib);
        logic [6:0] pat;
        case (nib)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

    // Double-dabble correction: a nibble of 5 or more gets 3 added before the shift.
    function automatic bcd_nibble_t dd_adjust(input bcd_nibble_t nib);
        bcd_nibble_t res;
        if (nib >= 4'd5) begin
            res = nib + 4'd3;
        end else begin
            res = nib;
        end
        return res;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Free-running sequential binary-to-BCD converter (double dabble).
// One conversion every 10 cycles: IDLE (capture) -> 8 x SHIFT -> LOAD.
// Ports:
//   clk   in   system clock
//   reset in   asynchronous active-high reset
//   bin   in   8-bit binary value, sampled only in IDLE
//   bcd   out  {hundreds,tens,units} result; stable while load is high
//   load  out  high for the single LOAD cycle; consumer captures bcd on that edge
// -----------------------------------------------------------------------------
module bin2bcd_seq
    import seg7_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  bin,
    output logic [11:0] bcd,
    output logic        load
);

    conv_state_e state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [11:0] acc_q,   acc_d;
    logic [2:0]  iter_q,  iter_d;
    logic [11:0] adj_s;

    // Per-nibble add-3 correction applied to the accumulator before each shift
    always_comb begin
        adj_s = {dd_adjust(acc_q[11:8]), dd_adjust(acc_q[7:4]), dd_adjust(acc_q[3:0])};
    end

    // Next-state and datapath for the IDLE/SHIFT/LOAD engine
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        acc_d   = acc_q;
        iter_d  = iter_q;
        case (state_q)
            ST_IDLE: begin
                shift_d = bin;
                acc_d   = 12'd0;
                iter_d  = 3'd0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                // Shift {accumulator, binary} left by one; hundreds never exceeds 2,
                // so adj_s[11] is always zero and nothing is lost off the top.
                {acc_d, shift_d} = {adj_s[10:0], shift_q, 1'b0};
                iter_d = iter_q + 3'd1;
                if (iter_q == 3'd7) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_LOAD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Converter state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shift_q <= 8'd0;
            acc_q   <= 12'd0;
            iter_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            iter_q  <= iter_d;
        end
    end

    // Result and load strobe are straight decodes of registered state
    always_comb begin
        bcd  = acc_q;
        load = (state_q == ST_LOAD);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Drives a three-digit common-anode seven-segment display from an 8-bit count.
// The value is converted to BCD continuously, leading zeros are blanked and
// the digits are time-multiplexed with a programmable scan divider.
// Parameters:
//   SCAN_DIV  cycles each digit stays selected (>= 2)
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous active-high reset
//   value  in   unsigned count 0..255
//   seg    out  segment drive {g,f,e,d,c,b,a}, active-low, registered
//   an     out  digit enables {hundreds,tens,units}, active-low, registered
//   valid  out  high once the first conversion has reached the digit registers
// -----------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 50000
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] value,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       valid
);

    localparam int                DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [11:0] bcd_s;
    logic        load_s;

    bcd_nibble_t hund_q,  hund_d;
    bcd_nibble_t tens_q,  tens_d;
    bcd_nibble_t units_q, units_d;
    logic        valid_q, valid_d;

    logic [DIV_W-1:0] div_q, div_d;
    digit_idx_t       idx_q, idx_d;

    logic [6:0]  seg_q, seg_d;
    logic [2:0]  an_q,  an_d;

    bcd_nibble_t sel_digit_s;
    logic        sel_blank_s;
    logic [2:0]  an_sel_s;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .bin   (value),
        .bcd   (bcd_s),
        .load  (load_s)
    );

    // Digit registers only change on the converter's LOAD strobe
    always_comb begin
        if (load_s) begin
            hund_d  = bcd_s[11:8];
            tens_d  = bcd_s[7:4];
            units_d = bcd_s[3:0];
            valid_d = 1'b1;
        end else begin
            hund_d  = hund_q;
            tens_d  = tens_q;
            units_d = units_q;
            valid_d = valid_q;
        end
    end

    // Scan divider and digit index: index advances units->tens->hundreds on wrap
    always_comb begin
        div_d = div_q;
        idx_d = idx_q;
        if (div_q == DIV_LAST) begin
            div_d = {DIV_W{1'b0}};
            if (idx_q == IDX_HUNDREDS) begin
                idx_d = IDX_UNITS;
            end else begin
                idx_d = idx_q + 2'd1;
            end
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Digit select and leading-zero blanking for the current index
    always_comb begin
        sel_digit_s = units_q;
        sel_blank_s = 1'b1;
        an_sel_s    = 3'b111;
        case (idx_q)
            IDX_UNITS: begin
                sel_digit_s = units_q;
                sel_blank_s = ~valid_q;
                an_sel_s    = 3'b110;
            end
            IDX_TENS: begin
                sel_digit_s = tens_q;
                sel_blank_s = ~valid_q | ((hund_q == 4'd0) && (tens_q == 4'd0));
                an_sel_s    = 3'b101;
            end
            IDX_HUNDREDS: begin
                sel_digit_s = hund_q;
                sel_blank_s = ~valid_q | (hund_q == 4'd0);
                an_sel_s    = 3'b011;
            end
            default: begin
                sel_digit_s = 4'd0;
                sel_blank_s = 1'b1;
                an_sel_s    = 3'b111;
            end
        endcase
        if (sel_blank_s) begin
            seg_d = SEG_BLANK;
            an_d  = 3'b111;
        end else begin
            seg_d = seg_decode(sel_digit_s);
            an_d  = an_sel_s;
        end
    end

    // All state and output registers; outputs are built from registered index and
    // digits, so a LOAD coinciding with a scan step shows both changes in one frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hund_q  <= 4'd0;
            tens_q  <= 4'd0;
            units_q <= 4'd0;
            valid_q <= 1'b0;
            div_q   <= {DIV_W{1'b0}};
            idx_q   <= IDX_UNITS;
            seg_q   <= SEG_BLANK;
            an_q    <= 3'b111;
        end else begin
            hund_q  <= hund_d;
            tens_q  <= tens_d;
            units_q <= units_d;
            valid_q <= valid_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    // Drive ports from their registers
    always_comb begin
        seg   = seg_q;
        an    = an_q;
        valid = valid_q;
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
// Self-checking bench for seg7_scan_driver with SCAN_DIV = 4. A cycle-count
// reference model derives the displayed digits with decimal arithmetic and the
// scan slot from the edge count since reset release.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

    localparam int SD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] value;
    logic [6:0] seg;
    logic [2:0] an;
    logic       valid;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state (state after the most recent model edge)
    int e;          // edges since reset release
    int cap_v;      // value captured at the last conversion start
    int shown_v;    // value currently held in the display digits
    bit m_valid;
    int m_idx;

    logic [6:0] pat [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    seg7_scan_driver #(.SCAN_DIV(SD)) dut (
        .clk   (clk),
        .reset (reset),
        .value (value),
        .seg   (seg),
        .an    (an),
        .valid (valid)
    );

    always #5 clk = ~clk;

    // Safety net: never hang
    initial begin
        #400000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at model edge %0d: got %0h expected %0h", tag, e, got, exp);
        end
    endtask

    // Expected display for a decimal value in a given scan slot
    function automatic void exp_out(input int v, input int idx, input bit vld,
                                    output logic [6:0] s, output logic [2:0] a);
        int  h, t, u, d;
        bit  blank;
        h = v / 100;
        t = (v / 10) % 10;
        u = v % 10;
        s = 7'h7F;
        a = 3'b111;
        d = 0;
        blank = 1'b1;
        if (vld) begin
            case (idx)
                0:       begin d = u; blank = 1'b0; end
                1:       begin d = t; blank = (h == 0) && (t == 0); end
                default: begin d = h; blank = (h == 0); end
            endcase
            if (!blank) begin
                s = pat[d];
                a = 3'b111 & ~(3'b001 << idx);
            end
        end
    endfunction

    // One clock: advance the model, compare outputs #1 after the edge, return at negedge
    task automatic tick();
        logic [6:0] es;
        logic [2:0] ea;
        @(posedge clk);
        e++;
        exp_out(shown_v, m_idx, m_valid, es, ea);
        if ((e - 1) % 10 == 0) cap_v = value;
        if (e % 10 == 0) begin
            shown_v = cap_v;
            m_valid = 1'b1;
        end
        m_idx = (e / SD) % 3;
        #1;
        check_eq("seg", seg, es);
        check_eq("an", an, ea);
        check_eq("valid", valid, m_valid);
        @(negedge clk);
    endtask

    // Assert reset (called at a negedge), check the immediate clear, release, reset model
    task automatic do_reset(input int cycles);
        reset = 1'b1;
        #1;
        check_eq("rst_seg", seg, 7'h7F);
        check_eq("rst_an", an, 3'b111);
        check_eq("rst_valid", valid, 1'b0);
        repeat (cycles) @(posedge clk);
        #1;
        check_eq("rst_hold_seg", seg, 7'h7F);
        check_eq("rst_hold_valid", valid, 1'b0);
        @(negedge clk);
        reset   = 1'b0;
        e       = 0;
        cap_v   = 0;
        shown_v = 0;
        m_valid = 1'b0;
        m_idx   = 0;
    endtask

    // Count ticks until valid rises (bounded) and expect exactly 10
    task automatic valid_latency(input string tag);
        int k;
        k = 0;
        while (!valid && k < 20) begin
            tick();
            k++;
        end
        check_eq(tag, k, 10);
    endtask

    // Over one 12-cycle scan period, check each slot's pattern and dwell count
    task automatic scan_frame(input string tag, input logic [6:0] s_u,
                              input logic [6:0] s_t, input logic [6:0] s_h);
        int c_u, c_t, c_h, c_b, n_blank;
        c_u = 0; c_t = 0; c_h = 0; c_b = 0;
        n_blank = ((s_u == 7'h7F) ? 1 : 0) + ((s_t == 7'h7F) ? 1 : 0) + ((s_h == 7'h7F) ? 1 : 0);
        for (int i = 0; i < 12; i++) begin
            tick();
            case (an)
                3'b110:  begin check_eq({tag, "_units"}, seg, s_u); c_u++; end
                3'b101:  begin check_eq({tag, "_tens"}, seg, s_t); c_t++; end
                3'b011:  begin check_eq({tag, "_hund"}, seg, s_h); c_h++; end
                3'b111:  begin check_eq({tag, "_blank"}, seg, 7'h7F); c_b++; end
                default: check_eq({tag, "_an_code"}, an, 3'b111);
            endcase
        end
        check_eq({tag, "_n_units"}, c_u, (s_u == 7'h7F) ? 0 : SD);
        check_eq({tag, "_n_tens"}, c_t, (s_t == 7'h7F) ? 0 : SD);
        check_eq({tag, "_n_hund"}, c_h, (s_h == 7'h7F) ? 0 : SD);
        check_eq({tag, "_n_blank"}, c_b, n_blank * SD);
    endtask

    initial begin
        int edge_vals [0:7];
        edge_vals = '{0, 9, 10, 99, 100, 199, 200, 255};
        reset = 1'b1;
        value = 8'd0;
        e = 0; cap_v = 0; shown_v = 0; m_valid = 1'b0; m_idx = 0;
        @(negedge clk);

        // 1. Reset for 3 cycles, valid 10 cycles after release
        do_reset(3);
        valid_latency("reset_valid_latency");

        // 2. Full value 255
        value = 8'd255;
        repeat (22) tick();
        scan_frame("v255", 7'h12, 7'h12, 7'h24);

        // 3. Two leading zeros blanked
        value = 8'd7;
        repeat (22) tick();
        scan_frame("v7", 7'h78, 7'h7F, 7'h7F);

        // 4. Three digits, zeros inside the number are shown
        value = 8'd100;
        repeat (22) tick();
        scan_frame("v100", 7'h40, 7'h40, 7'h79);

        // 5. Value changes mid-SHIFT: 42 loads first, then 43
        while (e % 10 != 0) tick();
        value = 8'd42;
        repeat (3) tick();
        value = 8'd43;
        repeat (30) tick();

        // 6. Reset in the 4th SHIFT cycle with 99 applied
        value = 8'd99;
        repeat (10) tick();
        while (e % 10 != 4) tick();
        do_reset(2);
        valid_latency("midshift_valid_latency");
        repeat (2) tick();
        scan_frame("v99", 7'h10, 7'h10, 7'h7F);

        // Randomized values with boundary picks and one asynchronous reset
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                if ($urandom_range(0, 3) == 0) begin
                    value = 8'(edge_vals[$urandom_range(0, 7)]);
                end else begin
                    value = 8'($urandom_range(0, 255));
                end
            end
            if (i == 700) begin
                do_reset(1 + $urandom_range(0, 2));
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
